// File: rtl/line_capture.sv
// rtl/line_capture.sv - EOS-windowed ADC line capture with buffered streaming drain
module line_capture #(
   parameter int NPIX = 1024,
   parameter int DW   = 12,
   parameter int AW   = 11
) (
   input  logic          FPGA_CLK,
   input  logic          FPGA_RST,
   input  logic          EOC_EDGE_FF,
   input  logic          EOS_EDGE_FF,
   input  logic          EOSF_EDGE_FF,
   input  logic [DW-1:0] ADC_DATA,
   input  logic          STAT_CLR,
   input  logic          PIX_READY,
   output logic          PIX_VALID,
   output logic [DW-1:0] PIX_DATA,
   output logic [AW-1:0] PIX_IDX,
   output logic          PIX_LAST,
   output logic          LINE_DONE,
   output logic [AW-1:0] LINE_LEN,
   output logic          OVERRUN,
   output logic          DROP
);

   localparam int            IW     = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [AW-1:0] NPIX_W = AW'(NPIX);

   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] len_q, len_d;
   logic          pend_q, pend_d;
   logic [AW-1:0] pend_idx_q, pend_idx_d;
   logic          out_v_q, out_v_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic [AW-1:0] out_idx_q, out_idx_d;
   logic          out_last_q, out_last_d;
   logic          skid_v_q, skid_v_d;
   logic [DW-1:0] skid_data_q, skid_data_d;
   logic [AW-1:0] skid_idx_q, skid_idx_d;
   logic          skid_last_q, skid_last_d;
   logic          line_done_q, line_done_d;
   logic          overrun_q, overrun_d;
   logic          drop_q, drop_d;

   logic          mem_we;
   logic          rd_issue;
   logic          pop;
   logic          pend_last;
   logic          overrun_set;
   logic          drop_set;
   logic [1:0]    stored_next;

   logic [DW-1:0] mem_q [NPIX];
   logic [DW-1:0] mem_rdata_q;

   // Next-state, capture/drain datapath and flag update
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      len_d       = len_q;
      pend_d      = 1'b0;
      pend_idx_d  = pend_idx_q;
      out_v_d     = out_v_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      skid_v_d    = skid_v_q;
      skid_data_d = skid_data_q;
      skid_idx_d  = skid_idx_q;
      skid_last_d = skid_last_q;
      line_done_d = 1'b0;
      mem_we      = 1'b0;
      rd_issue    = 1'b0;
      overrun_set = 1'b0;
      drop_set    = 1'b0;
      pop         = out_v_q & PIX_READY;
      pend_last   = (pend_idx_q == len_q - AW'(1));
      // words held in out/skid after this edge, before next cycle's pop
      stored_next = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, pend_q} - {1'b0, pop};

      case (state_q)
         IDLE: begin
            if (EOSF_EDGE_FF) begin
               state_d  = CAPTURE;
               wr_ptr_d = '0;
            end
         end
         CAPTURE: begin
            if (EOSF_EDGE_FF) begin
               wr_ptr_d = '0;
            end else begin
               if (EOC_EDGE_FF) begin
                  if (wr_ptr_q < NPIX_W) begin
                     mem_we   = 1'b1;
                     wr_ptr_d = wr_ptr_q + AW'(1);
                  end else begin
                     overrun_set = 1'b1;
                  end
               end
               if (EOS_EDGE_FF) begin
                  if (wr_ptr_d != '0) begin
                     len_d    = wr_ptr_d;
                     rd_ptr_d = '0;
                     state_d  = DRAIN;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         DRAIN: begin
            drop_set = EOSF_EDGE_FF;
            // only prefetch when the returning word is guaranteed a slot
            if ((rd_ptr_q < len_q) && (stored_next <= 2'd1)) begin
               rd_issue   = 1'b1;
               pend_d     = 1'b1;
               pend_idx_d = rd_ptr_q;
               rd_ptr_d   = rd_ptr_q + AW'(1);
            end
            if (pop || !out_v_q) begin
               if (skid_v_q) begin
                  out_v_d     = 1'b1;
                  out_data_d  = skid_data_q;
                  out_idx_d   = skid_idx_q;
                  out_last_d  = skid_last_q;
                  skid_v_d    = pend_q;
                  skid_data_d = mem_rdata_q;
                  skid_idx_d  = pend_idx_q;
                  skid_last_d = pend_last;
               end else if (pend_q) begin
                  out_v_d    = 1'b1;
                  out_data_d = mem_rdata_q;
                  out_idx_d  = pend_idx_q;
                  out_last_d = pend_last;
               end else begin
                  out_v_d = 1'b0;
               end
            end else if (pend_q) begin
               skid_v_d    = 1'b1;
               skid_data_d = mem_rdata_q;
               skid_idx_d  = pend_idx_q;
               skid_last_d = pend_last;
            end
            if (pop && out_last_q) begin
               out_v_d     = 1'b0;
               line_done_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      overrun_d = overrun_set | (overrun_q & ~STAT_CLR);
      drop_d    = drop_set | (drop_q & ~STAT_CLR);
   end

   // Control and output registers, cleared asynchronously
   always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
      if (!FPGA_RST) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         len_q       <= '0;
         pend_q      <= 1'b0;
         pend_idx_q  <= '0;
         out_v_q     <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         skid_v_q    <= 1'b0;
         skid_data_q <= '0;
         skid_idx_q  <= '0;
         skid_last_q <= 1'b0;
         line_done_q <= 1'b0;
         overrun_q   <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         len_q       <= len_d;
         pend_q      <= pend_d;
         pend_idx_q  <= pend_idx_d;
         out_v_q     <= out_v_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         skid_v_q    <= skid_v_d;
         skid_data_q <= skid_data_d;
         skid_idx_q  <= skid_idx_d;
         skid_last_q <= skid_last_d;
         line_done_q <= line_done_d;
         overrun_q   <= overrun_d;
         drop_q      <= drop_d;
      end
   end

   // Line buffer: synchronous write, registered read with one-cycle latency
   always_ff @(posedge FPGA_CLK) begin
      if (mem_we) begin
         mem_q[wr_ptr_q[IW-1:0]] <= ADC_DATA;
      end
      if (rd_issue) begin
         mem_rdata_q <= mem_q[rd_ptr_q[IW-1:0]];
      end
   end

   assign PIX_VALID = out_v_q;
   assign PIX_DATA  = out_data_q;
   assign PIX_IDX   = out_idx_q;
   assign PIX_LAST  = out_last_q;
   assign LINE_DONE = line_done_q;
   assign LINE_LEN  = len_q;
   assign OVERRUN   = overrun_q;
   assign DROP      = drop_q;

endmodule

// File: tb/tb_line_capture.sv
// tb/tb_line_capture.sv - scoreboard bench for line_capture
module tb_line_capture;

   localparam int NPIX = 8;
   localparam int DW   = 12;
   localparam int AW   = 4;
   localparam int EW   = DW + AW + 1;

   logic          FPGA_CLK     = 1'b0;
   logic          FPGA_RST     = 1'b0;
   logic          EOC_EDGE_FF  = 1'b0;
   logic          EOS_EDGE_FF  = 1'b0;
   logic          EOSF_EDGE_FF = 1'b0;
   logic [DW-1:0] ADC_DATA     = '0;
   logic          STAT_CLR     = 1'b0;
   logic          PIX_READY    = 1'b0;
   logic          PIX_VALID;
   logic [DW-1:0] PIX_DATA;
   logic [AW-1:0] PIX_IDX;
   logic          PIX_LAST;
   logic          LINE_DONE;
   logic [AW-1:0] LINE_LEN;
   logic          OVERRUN;
   logic          DROP;

   line_capture #(.NPIX(NPIX), .DW(DW), .AW(AW)) dut (
      .FPGA_CLK    (FPGA_CLK),
      .FPGA_RST    (FPGA_RST),
      .EOC_EDGE_FF (EOC_EDGE_FF),
      .EOS_EDGE_FF (EOS_EDGE_FF),
      .EOSF_EDGE_FF(EOSF_EDGE_FF),
      .ADC_DATA    (ADC_DATA),
      .STAT_CLR    (STAT_CLR),
      .PIX_READY   (PIX_READY),
      .PIX_VALID   (PIX_VALID),
      .PIX_DATA    (PIX_DATA),
      .PIX_IDX     (PIX_IDX),
      .PIX_LAST    (PIX_LAST),
      .LINE_DONE   (LINE_DONE),
      .LINE_LEN    (LINE_LEN),
      .OVERRUN     (OVERRUN),
      .DROP        (DROP)
   );

   always #5 FPGA_CLK = ~FPGA_CLK;

   int            n_run = 0;
   int            n_fail = 0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] obs_q[$];
   int            xfer_cyc[$];
   int            sb_cnt = 0;
   logic [AW-1:0] exp_len = '0;
   int            done_cnt, done_cyc, stall_err, first_valid, valid_cnt, post_err;

   task automatic sb_open();
      exp_q.delete();
      sb_cnt = 0;
   endtask

   task automatic sb_close();
      logic [EW-1:0] t;
      if (sb_cnt > 0) begin
         exp_len = AW'(sb_cnt);
         t = exp_q.pop_back();
         t[EW-1] = 1'b1;
         exp_q.push_back(t);
      end
   endtask

   task automatic pulse_eosf();
      EOSF_EDGE_FF = 1'b1;
      @(negedge FPGA_CLK);
      EOSF_EDGE_FF = 1'b0;
      sb_open();
   endtask

   task automatic pulse_eoc(input logic [DW-1:0] d, input logic with_eos, input logic clr);
      ADC_DATA    = d;
      EOC_EDGE_FF = 1'b1;
      EOS_EDGE_FF = with_eos;
      STAT_CLR    = clr;
      @(negedge FPGA_CLK);
      EOC_EDGE_FF = 1'b0;
      EOS_EDGE_FF = 1'b0;
      STAT_CLR    = 1'b0;
      if (sb_cnt < NPIX) begin
         exp_q.push_back({1'b0, AW'(sb_cnt), d});
         sb_cnt++;
      end
      if (with_eos) sb_close();
   endtask

   task automatic pulse_eos();
      EOS_EDGE_FF = 1'b1;
      @(negedge FPGA_CLK);
      EOS_EDGE_FF = 1'b0;
      sb_close();
   endtask

   // mode 0: ready always; 1: ready 1,0,0 repeating; 2: ready from cycle 6 on
   task automatic collect(input int max_cyc, input int mode, input int eosf_at);
      logic          stalled = 1'b0;
      logic [EW-1:0] held = '0;
      obs_q.delete();
      xfer_cyc.delete();
      done_cnt = 0; done_cyc = -1; stall_err = 0;
      first_valid = -1; valid_cnt = 0; post_err = 0;
      for (int c = 0; c < max_cyc; c++) begin
         if (LINE_DONE) begin
            done_cnt++;
            done_cyc = c;
            if (PIX_VALID) post_err++;
         end
         if (stalled && (!PIX_VALID || {PIX_LAST, PIX_IDX, PIX_DATA} !== held)) stall_err++;
         if (PIX_VALID) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = c;
         end
         case (mode)
            0:       PIX_READY = 1'b1;
            1:       PIX_READY = (c % 3 == 0);
            default: PIX_READY = (c >= 6);
         endcase
         EOSF_EDGE_FF = (c == eosf_at);
         if (PIX_VALID && PIX_READY) begin
            obs_q.push_back({PIX_LAST, PIX_IDX, PIX_DATA});
            xfer_cyc.push_back(c);
         end
         stalled = PIX_VALID && !PIX_READY;
         held    = {PIX_LAST, PIX_IDX, PIX_DATA};
         if (done_cyc >= 0 && c >= done_cyc + 3) break;
         @(negedge FPGA_CLK);
      end
      EOSF_EDGE_FF = 1'b0;
      PIX_READY    = 1'b0;
   endtask

   task automatic test_reset();
      logic [24:0] all_out;
      @(negedge FPGA_CLK);
      all_out = {PIX_VALID, PIX_DATA, PIX_IDX, PIX_LAST, LINE_DONE, LINE_LEN, OVERRUN, DROP};
      n_run++;
      if (all_out !== 25'd0) begin
         n_fail++; $display("FAIL reset_outputs got %h exp 0", all_out);
      end
      FPGA_RST = 1'b1;
      @(negedge FPGA_CLK);
   endtask

   task automatic test_basic();
      logic [EW-1:0] e, o;
      int last_x;
      pulse_eosf();
      for (int i = 1; i <= 5; i++) pulse_eoc(DW'(12'h100 + i), 1'b0, 1'b0);
      pulse_eos();
      collect(40, 0, -1);
      last_x = (xfer_cyc.size() > 0) ? xfer_cyc[xfer_cyc.size()-1] : -9;
      n_run++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL basic_count got %0d exp %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
         if (o !== e) begin n_fail++; $display("FAIL basic_word got %h exp %h", o, e); end
      end
      n_run++;
      if (first_valid !== 2) begin
         n_fail++; $display("FAIL basic_latency got %0d exp 2", first_valid);
      end
      n_run++;
      if (xfer_cyc.size() != 5 || last_x - xfer_cyc[0] != 4) begin
         n_fail++; $display("FAIL basic_back_to_back got span %0d exp 4", last_x - xfer_cyc[0]);
      end
      n_run++;
      if (done_cnt != 1 || done_cyc != last_x + 1 || post_err != 0) begin
         n_fail++; $display("FAIL basic_done got cnt %0d cyc %0d exp cnt 1 cyc %0d", done_cnt, done_cyc, last_x + 1);
      end
      n_run++;
      if (LINE_LEN !== 4'd5) begin
         n_fail++; $display("FAIL basic_len got %0d exp 5", LINE_LEN);
      end
   endtask

   task automatic test_backpressure();
      logic [EW-1:0] e, o;
      pulse_eosf();
      for (int i = 1; i <= 5; i++) pulse_eoc(DW'(12'h100 + i), 1'b0, 1'b0);
      pulse_eos();
      collect(60, 1, -1);
      n_run++;
      if (obs_q.size() != 5) begin
         n_fail++; $display("FAIL bp_count got %0d exp 5", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
         if (o !== e) begin n_fail++; $display("FAIL bp_word got %h exp %h", o, e); end
      end
      n_run++;
      if (stall_err != 0) begin
         n_fail++; $display("FAIL bp_stable got %0d unstable stalls exp 0", stall_err);
      end
      n_run++;
      if (done_cnt != 1) begin
         n_fail++; $display("FAIL bp_done got %0d exp 1", done_cnt);
      end
   endtask

   task automatic test_overrun();
      logic [EW-1:0] e, o;
      pulse_eosf();
      for (int i = 1; i <= 10; i++) pulse_eoc(DW'(i), 1'b0, 1'b0);
      pulse_eos();
      n_run++;
      if (OVERRUN !== 1'b1) begin
         n_fail++; $display("FAIL ovr_set got %b exp 1", OVERRUN);
      end
      collect(40, 0, -1);
      n_run++;
      if (obs_q.size() != 8) begin
         n_fail++; $display("FAIL ovr_count got %0d exp 8", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
         if (o !== e) begin n_fail++; $display("FAIL ovr_word got %h exp %h", o, e); end
      end
      n_run++;
      if (LINE_LEN !== 4'd8) begin
         n_fail++; $display("FAIL ovr_len got %0d exp 8", LINE_LEN);
      end
      STAT_CLR = 1'b1;
      @(negedge FPGA_CLK);
      STAT_CLR = 1'b0;
      n_run++;
      if (OVERRUN !== 1'b0) begin
         n_fail++; $display("FAIL ovr_clear got %b exp 0", OVERRUN);
      end
      pulse_eosf();
      for (int i = 1; i <= 8; i++) pulse_eoc(DW'(12'h020 + i), 1'b0, 1'b0);
      pulse_eoc(12'h0FF, 1'b0, 1'b1);
      n_run++;
      if (OVERRUN !== 1'b1) begin
         n_fail++; $display("FAIL ovr_set_wins_clear got %b exp 1", OVERRUN);
      end
      pulse_eos();
      collect(40, 0, -1);
      n_run++;
      if (obs_q.size() != 8 || done_cnt != 1) begin
         n_fail++; $display("FAIL ovr2_drain got %0d words %0d done exp 8 1", obs_q.size(), done_cnt);
      end
      STAT_CLR = 1'b1;
      @(negedge FPGA_CLK);
      STAT_CLR = 1'b0;
   endtask

   task automatic test_edges();
      logic [EW-1:0] e, o;
      pulse_eosf();
      pulse_eoc(12'h301, 1'b0, 1'b0);
      pulse_eoc(12'h302, 1'b0, 1'b0);
      pulse_eoc(12'h303, 1'b1, 1'b0);
      collect(40, 0, -1);
      n_run++;
      if (LINE_LEN !== 4'd3 || obs_q.size() != 3) begin
         n_fail++; $display("FAIL eoc_eos_len got len %0d words %0d exp 3 3", LINE_LEN, obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
         if (o !== e) begin n_fail++; $display("FAIL eoc_eos_word got %h exp %h", o, e); end
      end
      pulse_eosf();
      pulse_eos();
      collect(20, 0, -1);
      n_run++;
      if (valid_cnt != 0 || done_cnt != 0) begin
         n_fail++; $display("FAIL empty_line got valid %0d done %0d exp 0 0", valid_cnt, done_cnt);
      end
      n_run++;
      if (LINE_LEN !== 4'd3) begin
         n_fail++; $display("FAIL empty_len_hold got %0d exp 3", LINE_LEN);
      end
   endtask

   task automatic test_drop();
      logic [EW-1:0] e, o;
      pulse_eosf();
      for (int i = 1; i <= 4; i++) pulse_eoc(DW'(12'h400 + i), 1'b0, 1'b0);
      pulse_eos();
      collect(40, 2, 3);
      n_run++;
      if (DROP !== 1'b1) begin
         n_fail++; $display("FAIL drop_set got %b exp 1", DROP);
      end
      n_run++;
      if (obs_q.size() != 4 || done_cnt != 1) begin
         n_fail++; $display("FAIL drop_drain got %0d words %0d done exp 4 1", obs_q.size(), done_cnt);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
         if (o !== e) begin n_fail++; $display("FAIL drop_word got %h exp %h", o, e); end
      end
      for (int i = 0; i < 2; i++) begin
         ADC_DATA = 12'hBAD; EOC_EDGE_FF = 1'b1;
         @(negedge FPGA_CLK);
         EOC_EDGE_FF = 1'b0;
      end
      EOS_EDGE_FF = 1'b1;
      @(negedge FPGA_CLK);
      EOS_EDGE_FF = 1'b0;
      collect(15, 0, -1);
      n_run++;
      if (valid_cnt != 0) begin
         n_fail++; $display("FAIL drop_not_captured got %0d valid cycles exp 0", valid_cnt);
      end
      STAT_CLR = 1'b1;
      @(negedge FPGA_CLK);
      STAT_CLR = 1'b0;
      n_run++;
      if (DROP !== 1'b0) begin
         n_fail++; $display("FAIL drop_clear got %b exp 0", DROP);
      end
   endtask

   task automatic test_restart();
      logic [EW-1:0] e, o;
      pulse_eosf();
      for (int i = 1; i <= 3; i++) pulse_eoc(DW'(12'h500 + i), 1'b0, 1'b0);
      pulse_eosf();
      pulse_eoc(12'h511, 1'b0, 1'b0);
      pulse_eoc(12'h512, 1'b0, 1'b0);
      pulse_eos();
      collect(40, 0, -1);
      n_run++;
      if (LINE_LEN !== 4'd2 || obs_q.size() != 2) begin
         n_fail++; $display("FAIL restart_len got len %0d words %0d exp 2 2", LINE_LEN, obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
         if (o !== e) begin n_fail++; $display("FAIL restart_word got %h exp %h", o, e); end
      end
   endtask

   task automatic test_async_reset();
      logic [EW-1:0] e, o;
      logic [24:0]   all_out;
      pulse_eosf();
      for (int i = 1; i <= 5; i++) pulse_eoc(DW'(12'h600 + i), 1'b0, 1'b0);
      pulse_eos();
      PIX_READY = 1'b0;
      repeat (4) @(negedge FPGA_CLK);
      n_run++;
      if (PIX_VALID !== 1'b1) begin
         n_fail++; $display("FAIL rst_pre_valid got %b exp 1", PIX_VALID);
      end
      #2 FPGA_RST = 1'b0;
      #1;
      all_out = {PIX_VALID, PIX_DATA, PIX_IDX, PIX_LAST, LINE_DONE, LINE_LEN, OVERRUN, DROP};
      n_run++;
      if (all_out !== 25'd0) begin
         n_fail++; $display("FAIL rst_async_outputs got %h exp 0", all_out);
      end
      PIX_READY = 1'b1;
      repeat (2) @(negedge FPGA_CLK);
      FPGA_RST = 1'b1;
      @(negedge FPGA_CLK);
      n_run++;
      if (LINE_DONE !== 1'b0 || PIX_VALID !== 1'b0) begin
         n_fail++; $display("FAIL rst_no_done got done %b valid %b exp 0 0", LINE_DONE, PIX_VALID);
      end
      PIX_READY = 1'b0;
      pulse_eosf();
      for (int i = 1; i <= 3; i++) pulse_eoc(DW'(12'h700 + i), 1'b0, 1'b0);
      pulse_eos();
      collect(40, 0, -1);
      n_run++;
      if (obs_q.size() != 3 || LINE_LEN !== 4'd3) begin
         n_fail++; $display("FAIL rst_recover got %0d words len %0d exp 3 3", obs_q.size(), LINE_LEN);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
         if (o !== e) begin n_fail++; $display("FAIL rst_recover_word got %h exp %h", o, e); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_overrun();
      test_edges();
      test_drop();
      test_restart();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
